// File: rtl/rfphoenix_wb_arbiter.sv
// rtl/rfphoenix_wb_arbiter.sv - three-master Wishbone round-robin arbiter with ack timeout
// Masters: 0=icache, 1=dcache, 2=dma. Grant is held for the whole m_cyc_i of the owner.
module rfphoenix_wb_arbiter #(
    parameter int unsigned TMO = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [2:0]   m_cyc_i,
    input  logic [2:0]   m_stb_i,
    input  logic [2:0]   m_we_i,
    input  logic [8:0]   m_cti_i,
    input  logic [5:0]   m_bte_i,
    input  logic [47:0]  m_sel_i,
    input  logic [95:0]  m_adr_i,
    input  logic [383:0] m_dat_i,
    output logic [2:0]   m_ack_o,
    output logic [2:0]   m_err_o,
    output logic [127:0] m_dat_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [2:0]   s_cti_o,
    output logic [1:0]   s_bte_o,
    output logic [15:0]  s_sel_o,
    output logic [31:0]  s_adr_o,
    output logic [127:0] s_dat_o,
    input  logic         s_ack_i,
    input  logic         s_err_i,
    input  logic [127:0] s_dat_i,
    output logic [2:0]   gnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    localparam logic [15:0] TMO_LIM = 16'(TMO);

    logic [1:0]  state;
    logic [1:0]  last_gnt;
    logic [15:0] tmo_cnt;
    logic [1:0]  gidx;
    logic        cyc_g;
    logic        busy;
    logic        tmo_hit;
    logic [2:0]  next_gnt;
    logic        mux_cyc;
    logic        mux_stb;
    logic        mux_we;
    logic [15:0] mux_sel;

    always_comb begin
        gidx = 2'd0;
        if (gnt_o[1]) gidx = 2'd1;
        if (gnt_o[2]) gidx = 2'd2;
    end

    // Search order starts at the master after the last owner.
    always_comb begin
        next_gnt = 3'b000;
        case (last_gnt)
            2'd0: next_gnt = m_cyc_i[1] ? 3'b010 : m_cyc_i[2] ? 3'b100 : m_cyc_i[0] ? 3'b001 : 3'b000;
            2'd1: next_gnt = m_cyc_i[2] ? 3'b100 : m_cyc_i[0] ? 3'b001 : m_cyc_i[1] ? 3'b010 : 3'b000;
            default: next_gnt = m_cyc_i[0] ? 3'b001 : m_cyc_i[1] ? 3'b010 : m_cyc_i[2] ? 3'b100 : 3'b000;
        endcase
    end

    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_sel = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_o[i]) begin
                mux_cyc = m_cyc_i[i];
                mux_stb = m_stb_i[i];
                mux_we  = m_we_i[i];
                mux_sel = m_sel_i[16*i +: 16];
                s_cti_o = m_cti_i[3*i +: 3];
                s_bte_o = m_bte_i[2*i +: 2];
                s_adr_o = m_adr_i[32*i +: 32];
                s_dat_o = m_dat_i[128*i +: 128];
            end
        end
    end

    assign cyc_g   = |(m_cyc_i & gnt_o);
    assign busy    = (state == ST_BUSY) && !rst_i;
    // A slave response in the same cycle as the limit wins over the timeout.
    assign tmo_hit = busy && cyc_g && (tmo_cnt >= TMO_LIM) && !s_ack_i && !s_err_i;

    assign s_cyc_o = busy & mux_cyc;
    assign s_stb_o = busy & mux_stb;
    assign s_we_o  = busy & mux_we;
    assign s_sel_o = busy ? mux_sel : 16'h0000;
    assign m_ack_o = busy ? (gnt_o & {3{s_ack_i}}) : 3'b000;
    assign m_err_o = busy ? (gnt_o & {3{s_err_i | tmo_hit}}) : 3'b000;
    assign m_dat_o = s_dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            gnt_o    <= 3'b000;
            last_gnt <= 2'd2;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|m_cyc_i) begin
                        gnt_o   <= next_gnt;
                        state   <= ST_BUSY;
                        tmo_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!cyc_g) begin
                        state    <= ST_IDLE;
                        gnt_o    <= 3'b000;
                        last_gnt <= gidx;
                    end else begin
                        if (tmo_hit) state <= ST_ABORT;
                        if (s_ack_i || s_err_i) tmo_cnt <= '0;
                        else if (s_stb_o && (tmo_cnt != 16'hFFFF)) tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_ABORT: begin
                    if (!cyc_g) begin
                        state    <= ST_IDLE;
                        gnt_o    <= 3'b000;
                        last_gnt <= gidx;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_o <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: doc/rfphoenix_wb_arbiter.md
RFPHOENIX_WB_ARBITER -- requirements
Module: rfphoenix_wb_arbiter

Interface
REQ-001 SHALL have parameter TMO, default 255, meaning ack-timeout limit in clk_i cycles; legal range 2..65535.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk_i  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have port m_cyc_i  in  3  per-master bus cycle; index 0=icache, 1=dcache, 2=dma.
REQ-006 SHALL have port m_stb_i  in  3  per-master strobe.
REQ-007 SHALL have port m_we_i  in  3  per-master write enable.
REQ-008 SHALL have port m_cti_i  in  9  per-master cycle type, 3 bits each, master n at [3n+2:3n].
REQ-009 SHALL have port m_bte_i  in  6  per-master burst type, 2 bits each.
REQ-010 SHALL have port m_sel_i  in  48  per-master byte selects, 16 bits each.
REQ-011 SHALL have port m_adr_i  in  96  per-master address, 32 bits each.
REQ-012 SHALL have port m_dat_i  in  384  per-master write data, 128 bits each.
REQ-013 SHALL have port m_ack_o  out  3  per-master acknowledge.
REQ-014 SHALL have port m_err_o  out  3  per-master error.
REQ-015 SHALL have port m_dat_o  out  128  read data, broadcast to all masters.
REQ-016 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side bus controls.
REQ-017 SHALL have ports s_cti_o  out  3, s_bte_o  out  2, s_sel_o  out  16, s_adr_o  out  32, s_dat_o  out  128.
REQ-018 SHALL have ports s_ack_i  in  1, s_err_i  in  1, s_dat_i  in  128.
REQ-019 SHALL have port gnt_o  out  3  registered one-hot grant; all zero when idle.

Function
REQ-020 SHALL implement states IDLE, BUSY and ABORT.
REQ-021 In IDLE with any m_cyc_i set, SHALL grant the requester next in round-robin order after last_gnt (search order last_gnt+1, +2, +3, mod 3), load gnt_o and enter BUSY on the same edge.
REQ-022 Request seen in IDLE at edge N SHALL have s_cyc_o asserted from edge N+1; arbitration latency is 1 cycle.
REQ-023 In BUSY, s_* outputs SHALL equal the granted master's signals (combinational mux from gnt_o); s_dat_o from the same master.
REQ-024 In IDLE and ABORT, s_cyc_o, s_stb_o and s_we_o SHALL be 0, and s_sel_o SHALL be 0.
REQ-025 m_ack_o[g] SHALL be s_ack_i and m_err_o[g] SHALL be s_err_i for the granted g only; non-granted bits SHALL be 0.
REQ-026 m_dat_o SHALL be s_dat_i unconditionally.
REQ-027 Grant SHALL be held for the whole time the granted m_cyc_i stays high, including burst cycles with stb low and cti changes; no preemption.
REQ-028 When the granted m_cyc_i is low in BUSY, SHALL return to IDLE, clear gnt_o, set last_gnt to g; a new grant needs one IDLE cycle (no back-to-back grant).
REQ-029 Timeout counter (16 bits) SHALL clear on entering BUSY and on each s_ack_i or s_err_i, increment while s_stb_o=1 with no ack/err, and saturate.
REQ-030 When the counter reaches TMO in BUSY, SHALL pulse m_err_o[g] for exactly one cycle, enter ABORT, and keep gnt_o.
REQ-031 In ABORT, SHALL wait until m_cyc_i[g]=0, then go to IDLE with last_gnt=g.
REQ-032 s_ack_i and timeout in the same cycle SHALL treat the ack as winning, with no error pulse.
REQ-033 s_ack_i or s_err_i arriving in IDLE or ABORT SHALL be ignored.

Reset
REQ-034 On rst_i, SHALL set state to IDLE, gnt_o to 0, last_gnt to 2 (so master 0 wins first), and the counter to 0, and SHALL force all s_* controls, m_ack_o and m_err_o to 0 in that cycle.
REQ-035 Reset mid-transfer SHALL drop s_cyc_o at the next edge regardless of the masters' m_cyc_i.

Verification
REQ-036 Bench: out of reset, m_cyc_i=001 with adr 0xFF960000 -> gnt_o=001 one cycle later, s_adr_o=0xFF960000, and s_ack_i is returned on m_ack_o[0] only.
REQ-037 Bench: m_cyc_i=111 held with each cycle 1 ack long -> grant order 0,1,2,0, with one IDLE cycle between grants.
REQ-038 Bench: master 1 runs a 4-beat burst (cti 010...111) with stb gaps while master 2 requests -> master 2 is not granted until m_cyc_i[1] falls.
REQ-039 Bench: TMO=8, master 2 strobes and the slave never acks -> m_err_o=100 for one cycle at count 8, s_cyc_o=0 in ABORT, and IDLE after m_cyc_i[2] falls.
REQ-040 Bench: s_err_i during master 0's cycle -> m_err_o=001 and no timeout; ack coincident with count==TMO -> ack only.
REQ-041 Bench: rst_i asserted mid-burst -> next edge gives s_cyc_o=0 and gnt_o=000, and the first grant afterwards goes to master 0.
